// File: rtl/jstk_poll_ctrl.sv
// jstk_poll_ctrl: polling sequencer for the PMOD joystick SPI master.
// Periodically triggers a 40-bit transfer carrying the LED command, then
// decodes the returned bytes into X/Y position and button samples.
module jstk_poll_ctrl #(
  parameter int POLL_CYCLES    = 500000,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  leds,
  input  logic        spi_cs,
  input  logic [39:0] spi_in_bytes,
  output logic        spi_trigger,
  output logic [39:0] spi_out_bytes,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  buttons,
  output logic        sample_valid,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_BUSY,
    S_CAPTURE
  } state_t;

  // The period counter is zeroed on START entry; leaving WAIT two counts
  // early lets the IDLE->START hop land exactly POLL_CYCLES after the last start.
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 2);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_period_cnt;
  logic [31:0] r_tmo_cnt;
  logic        r_trigger;
  logic [39:0] r_out_bytes;
  logic [9:0]  r_x_pos;
  logic [9:0]  r_y_pos;
  logic [2:0]  r_buttons;
  logic        r_sample_valid;
  logic        r_timeout_err;

  logic        w_tmo_hit;
  logic        w_period_done;
  logic        w_unused;

  assign w_tmo_hit     = (r_tmo_cnt >= TMO_LAST);
  assign w_period_done = (r_period_cnt >= POLL_LAST);

  // Bits of the received word that carry no position or button information.
  assign w_unused = ^{spi_in_bytes[31:26], spi_in_bytes[15:10], spi_in_bytes[7:3]};

  // Poll sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_period_cnt   <= '0;
      r_tmo_cnt      <= '0;
      r_trigger      <= 1'b0;
      r_out_bytes    <= '0;
      r_x_pos        <= '0;
      r_y_pos        <= '0;
      r_buttons      <= '0;
      r_sample_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (r_state != S_IDLE) begin
        r_period_cnt <= r_period_cnt + 32'd1;
      end
      case (r_state)
        S_IDLE: begin
          // Only start when the master is idle, so a frame still running
          // after a reset is never overlapped.
          if (enable && spi_cs) begin
            r_state      <= S_START;
            r_trigger    <= 1'b1;
            r_out_bytes  <= {6'b100000, leds, 32'h0};
            r_period_cnt <= '0;
            r_tmo_cnt    <= '0;
          end
        end
        S_START: begin
          if (!spi_cs) begin
            r_trigger <= 1'b0;
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
            r_state   <= S_BUSY;
          end else if (w_tmo_hit) begin
            r_trigger     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_WAIT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
        end
        S_BUSY: begin
          if (spi_cs) begin
            r_state <= S_CAPTURE;
          end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_WAIT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
        end
        S_CAPTURE: begin
          r_x_pos        <= {spi_in_bytes[25:24], spi_in_bytes[39:32]};
          r_y_pos        <= {spi_in_bytes[9:8], spi_in_bytes[23:16]};
          r_buttons      <= spi_in_bytes[2:0];
          r_sample_valid <= 1'b1;
          r_state        <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable || w_period_done) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_trigger <= 1'b0;
        end
      endcase
    end
  end

  assign spi_trigger   = r_trigger;
  assign spi_out_bytes = r_out_bytes;
  assign x_pos         = r_x_pos;
  assign y_pos         = r_y_pos;
  assign buttons       = r_buttons;
  assign sample_valid  = r_sample_valid;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Bench for jstk_poll_ctrl: behavioural SPI slave, transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_jstk_poll_ctrl;

  localparam int P = 5000;
  localparam int T = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  leds;
  logic        spi_cs;
  logic [39:0] spi_in_bytes;
  logic        spi_trigger;
  logic [39:0] spi_out_bytes;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  buttons;
  logic        sample_valid;
  logic        timeout_err;

  jstk_poll_ctrl #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .enable(enable), .leds(leds),
    .spi_cs(spi_cs), .spi_in_bytes(spi_in_bytes),
    .spi_trigger(spi_trigger), .spi_out_bytes(spi_out_bytes),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .sample_valid(sample_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // ---------------- slave model ----------------
  bit          slv_en    = 1'b1;
  int          slv_delay = 10;
  int          slv_len   = 200;
  logic [39:0] slv_data  = 40'h0;
  logic        slv_prev  = 1'b0;

  initial begin
    spi_cs       = 1'b1;
    spi_in_bytes = 40'h0;
    forever begin
      @(negedge clk);
      if (slv_en && spi_trigger && !slv_prev) begin
        repeat (slv_delay) @(negedge clk);
        spi_cs = 1'b0;
        repeat (slv_len - 1) @(negedge clk);
        spi_in_bytes = slv_data;
        @(negedge clk);
        spi_cs = 1'b1;
      end
      slv_prev = spi_trigger;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [22:0] decode(input logic [39:0] w);
    int b [5];
    int x, y, k;
    for (int i = 0; i < 5; i++) b[i] = int'((w >> (8 * (4 - i))) & 40'hFF);
    x = (b[1] % 4) * 256 + b[0];
    y = (b[3] % 4) * 256 + b[2];
    k = b[4] % 8;
    return {10'(x), 10'(y), 3'(k)};
  endfunction

  function automatic logic [39:0] cmd(input logic [1:0] l);
    logic [39:0] c;
    c = 40'(128 + int'(l)) << 32;
    return c;
  endfunction

  int          cyc = 0;
  bit          in_xfer = 0, cs_fell = 0;
  int          e0 = 0, valid_due = -1;
  logic [9:0]  exp_x = 0, exp_y = 0;
  logic [2:0]  exp_b = 0;
  logic        exp_err = 0, exp_trig = 0;
  logic [39:0] exp_out = 0;
  logic        trig_prev = 0, cs_prev = 1;
  int          rise_count = 0, fall_count = 0, valid_count = 0;
  int          cs_fall_count = 0, cs_rise_count = 0;
  int          last_rise = 0, last_fall = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        in_xfer = 0; cs_fell = 0; valid_due = -1;
        exp_x = 0; exp_y = 0; exp_b = 0; exp_err = 0; exp_out = 0;
      end else begin
        if (cyc == valid_due) {exp_x, exp_y, exp_b} = decode(spi_in_bytes);
        if (in_xfer) begin
          if (!cs_fell && !spi_cs) cs_fell = 1;
          else if (cs_fell && spi_cs) begin in_xfer = 0; valid_due = cyc + 1; end
          else if (cyc - e0 == T) begin in_xfer = 0; exp_err = 1; end
        end else if (spi_trigger && !trig_prev) begin
          in_xfer = 1; cs_fell = 0; e0 = cyc; exp_out = cmd(leds);
        end
      end
      exp_trig = in_xfer && !cs_fell;
      chk("trigger", 64'(spi_trigger), 64'(exp_trig));
      chk("out_bytes", 64'(spi_out_bytes), 64'(exp_out));
      chk("x_pos", 64'(x_pos), 64'(exp_x));
      chk("y_pos", 64'(y_pos), 64'(exp_y));
      chk("buttons", 64'(buttons), 64'(exp_b));
      chk("sample_valid", 64'(sample_valid), 64'(cyc == valid_due));
      chk("timeout_err", 64'(timeout_err), 64'(exp_err));
      if (spi_trigger && !trig_prev) begin rise_count++; last_rise = cyc; end
      if (!spi_trigger && trig_prev) begin fall_count++; last_fall = cyc; end
      if (sample_valid) valid_count++;
      if (!spi_cs && cs_prev) cs_fall_count++;
      if (spi_cs && !cs_prev) cs_rise_count++;
      trig_prev = spi_trigger;
      cs_prev   = spi_cs;
    end
  end

  // ---------------- directed scenarios ----------------
  function automatic int ev(input int k);
    case (k)
      0: return rise_count;
      1: return fall_count;
      2: return valid_count;
      3: return cs_fall_count;
      default: return cs_rise_count;
    endcase
  endfunction

  task automatic wait_ev(input int k, input int budget, input string nm);
    int c0;
    int i;
    c0 = ev(k);
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (ev(k) != c0) break;
    end
    chk({"wait_", nm}, 64'(i < budget), 64'd1);
  endtask

  int t0, t1, v0, r0;

  initial begin
    rst = 1'b1; enable = 1'b0; leds = 2'b10;
    slv_data = 40'h34_02_C1_03_05;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("reset_out_bytes", 64'(spi_out_bytes), 64'h0);
    chk("reset_trigger", 64'(spi_trigger), 64'h0);

    // basic capture and periodic poll
    @(negedge clk); enable = 1'b1;
    wait_ev(0, 20, "rise1");
    t0 = last_rise;
    chk("cmd_leds10", 64'(spi_out_bytes), 64'h82_0000_0000);
    wait_ev(2, 400, "valid1");
    chk("x1", 64'(x_pos), 64'h234);
    chk("y1", 64'(y_pos), 64'h3C1);
    chk("btn1", 64'(buttons), 64'b101);
    chk("valid1_pulse", 64'(sample_valid), 64'd1);
    @(posedge clk); #2;
    chk("valid1_drop", 64'(sample_valid), 64'd0);
    slv_data = 40'hA5_01_3C_02_07;
    wait_ev(0, 6000, "rise2");
    t1 = last_rise;
    chk("period_1_2", 64'(t1 - t0), 64'(P));
    wait_ev(2, 400, "valid2");
    chk("x2", 64'(x_pos), 64'h1A5);
    chk("y2", 64'(y_pos), 64'h23C);
    chk("btn2", 64'(buttons), 64'b111);
    slv_data = 40'h7F_00_80_02_02;

    // leds change during START
    wait_ev(0, 6000, "rise3");
    chk("period_2_3", 64'(last_rise - t1), 64'(P));
    @(negedge clk); leds = 2'b01;
    @(posedge clk); #2;
    chk("cmd_held", 64'(spi_out_bytes), 64'h82_0000_0000);
    wait_ev(2, 400, "valid3");
    slv_data = 40'h00_03_FF_01_00;
    wait_ev(0, 6000, "rise4");
    chk("cmd_leds01", 64'(spi_out_bytes), 64'h81_0000_0000);

    // enable drop during BUSY
    wait_ev(3, 50, "csfall4");
    @(negedge clk); enable = 1'b0;
    wait_ev(2, 400, "valid4");
    chk("x4", 64'(x_pos), 64'h300);
    chk("y4", 64'(y_pos), 64'h1FF);
    chk("btn4", 64'(buttons), 64'b000);
    r0 = rise_count;
    repeat (6000) @(negedge clk);
    chk("no_trigger_disabled", 64'(rise_count - r0), 64'd0);

    // timeout with an unresponsive slave
    slv_en = 1'b0;
    enable = 1'b1;
    wait_ev(0, 10, "rise_tmo");
    t0 = last_rise;
    wait_ev(1, 400, "fall_tmo");
    chk("tmo_length", 64'(last_fall - t0), 64'(T));
    chk("tmo_err", 64'(timeout_err), 64'd1);
    chk("tmo_x_kept", 64'(x_pos), 64'h300);
    wait_ev(0, 6000, "rise_after_tmo");
    chk("tmo_period", 64'(last_rise - t0), 64'(P));
    wait_ev(1, 400, "fall_tmo2");
    @(negedge clk); enable = 1'b0; slv_en = 1'b1;
    repeat (5) @(negedge clk);

    // reset mid-BUSY
    enable = 1'b1;
    wait_ev(0, 10, "rise_rst");
    wait_ev(3, 50, "csfall_rst");
    repeat (100) @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk); rst = 1'b0;
    chk("rst_trigger", 64'(spi_trigger), 64'd0);
    chk("rst_err", 64'(timeout_err), 64'd0);
    chk("rst_x", 64'(x_pos), 64'd0);
    chk("rst_out", 64'(spi_out_bytes), 64'd0);
    v0 = valid_count;
    wait_ev(4, 300, "csrise_rst");
    repeat (5) @(negedge clk);
    chk("rst_no_valid", 64'(valid_count - v0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
